// File: rtl/controlador_botones_pkg.sv
// Shared types, default repeat timing and the button priority encoder
// for the front-panel command sequencer.
package pkg_botones;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        EMITIR   = 2'd1,
        MANTENER = 2'd2
    } estado_t;

    localparam int unsigned RETARDO_REP_DEF = 50_000_000;
    localparam int unsigned PERIODO_REP_DEF = 10_000_000;

    // Lowest set bit wins; an all-zero vector yields index 0.
    function automatic logic [3:0] prioridad(input logic [15:0] v);
        logic hallado;
        prioridad = '0;
        hallado   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i] && !hallado) begin
                prioridad = 4'(i);
                hallado   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/controlador_botones_temporizador_repeticion.sv
// Loadable down-counter for auto-repeat timing; stops at zero instead of
// wrapping.
module temporizador_repeticion #(
    parameter int unsigned ANCHO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cargar,
    input  logic [ANCHO-1:0] i_valor,
    input  logic             i_habilitar,
    output logic             o_cero
);

    logic [ANCHO-1:0] r_cuenta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cuenta <= '0;
        end else if (i_cargar) begin
            r_cuenta <= i_valor;
        end else if (i_habilitar && !o_cero) begin
            r_cuenta <= r_cuenta - ANCHO'(1);
        end
    end

    assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/controlador_botones.sv
// Turns debounced button presses into indexed commands over valid/ready,
// with fixed-priority arbitration and auto-repeat while held.
module controlador_botones
    import pkg_botones::*;
#(
    parameter int unsigned N_BOTONES   = 4,
    parameter int unsigned RETARDO_REP = RETARDO_REP_DEF,
    parameter int unsigned PERIODO_REP = PERIODO_REP_DEF
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [N_BOTONES-1:0]         botones,
    input  logic                         listo,
    output logic                         comando_valido,
    output logic [$clog2(N_BOTONES)-1:0] comando,
    output logic                         repeticion
);

    localparam int unsigned W_CMD   = $clog2(N_BOTONES);
    localparam int unsigned MAX_REP = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
    localparam int unsigned W_CNT   = (MAX_REP > 1) ? $clog2(MAX_REP) : 1;
    localparam logic [W_CNT-1:0] CNT_RETARDO = W_CNT'(RETARDO_REP - 1);
    localparam logic [W_CNT-1:0] CNT_PERIODO = W_CNT'(PERIODO_REP - 1);

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic [N_BOTONES-1:0]   r_prev;
    logic [N_BOTONES-1:0]   w_flanco;
    logic                   r_valido;
    logic                   w_valido_sig;
    logic [W_CMD-1:0]       r_comando;
    logic [W_CMD-1:0]       w_comando_sig;
    logic                   r_rep;
    logic                   w_rep_sig;
    logic                   w_transfer;
    logic                   w_cargar;
    logic [W_CNT-1:0]       w_valor;
    logic                   w_habilitar;
    logic                   w_cero;

    assign w_flanco   = botones & ~r_prev;
    assign w_transfer = r_valido & listo;

    temporizador_repeticion #(
        .ANCHO (W_CNT)
    ) u_temporizador (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_cargar    (w_cargar),
        .i_valor     (w_valor),
        .i_habilitar (w_habilitar),
        .o_cero      (w_cero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_estado  <= REPOSO;
            r_prev    <= '1;
            r_valido  <= 1'b0;
            r_comando <= '0;
            r_rep     <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_prev    <= botones;
            r_valido  <= w_valido_sig;
            r_comando <= w_comando_sig;
            r_rep     <= w_rep_sig;
        end
    end

    // r_comando doubles as the latched button index while holding.
    always_comb begin
        w_estado_sig  = r_estado;
        w_valido_sig  = r_valido;
        w_comando_sig = r_comando;
        w_rep_sig     = r_rep;
        w_cargar      = 1'b0;
        w_valor       = '0;
        w_habilitar   = 1'b0;
        case (r_estado)
            REPOSO: begin
                if (|w_flanco) begin
                    w_estado_sig  = EMITIR;
                    w_valido_sig  = 1'b1;
                    w_comando_sig = W_CMD'(prioridad(16'(w_flanco)));
                    w_rep_sig     = 1'b0;
                end
            end
            EMITIR: begin
                if (w_transfer) begin
                    w_estado_sig = MANTENER;
                    w_valido_sig = 1'b0;
                    w_cargar     = 1'b1;
                    w_valor      = r_rep ? CNT_PERIODO : CNT_RETARDO;
                end
            end
            MANTENER: begin
                if (!botones[r_comando]) begin
                    w_estado_sig = REPOSO;
                end else if (w_cero) begin
                    w_estado_sig = EMITIR;
                    w_valido_sig = 1'b1;
                    w_rep_sig    = 1'b1;
                end else begin
                    w_habilitar = 1'b1;
                end
            end
            default: begin
                w_estado_sig = REPOSO;
                w_valido_sig = 1'b0;
            end
        endcase
    end

    assign comando_valido = r_valido;
    assign comando        = r_comando;
    assign repeticion     = r_rep;

endmodule

// File: tb/tb_controlador_botones.sv
// Directed and randomized checks of controlador_botones against a
// cycle-count reference model of the command/repeat rules.
module tb_controlador_botones;

    localparam int unsigned NB = 4;
    localparam int unsigned R  = 8;
    localparam int unsigned P  = 3;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] botones;
    logic       listo;
    logic       comando_valido;
    logic [1:0] comando;
    logic       repeticion;

    int checks = 0;
    int errors = 0;

    // Reference model: pending command, holding a button, absolute repeat deadline.
    bit         m_pend;
    bit         m_hold;
    bit         m_rep;
    int         m_idx;
    int         m_next;
    int         n;
    logic [3:0] m_prev;

    always #5 CLK = ~CLK;

    controlador_botones #(
        .N_BOTONES   (NB),
        .RETARDO_REP (R),
        .PERIODO_REP (P)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .botones        (botones),
        .listo          (listo),
        .comando_valido (comando_valido),
        .comando        (comando),
        .repeticion     (repeticion)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        m_hold = 1'b0;
        m_rep  = 1'b0;
        m_idx  = 0;
        m_next = 0;
        m_prev = '1;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic l);
        logic [3:0] e;
        n++;
        if (m_pend) begin
            if (l) begin
                m_pend = 1'b0;
                m_hold = 1'b1;
                m_next = n + (m_rep ? int'(P) : int'(R));
            end
        end else if (m_hold) begin
            if (!b[m_idx]) begin
                m_hold = 1'b0;
            end else if (n == m_next) begin
                m_pend = 1'b1;
                m_rep  = 1'b1;
            end
        end else begin
            e = b & ~m_prev;
            if (e != 4'b0000) begin
                m_pend = 1'b1;
                m_rep  = 1'b0;
                for (int i = NB - 1; i >= 0; i--) begin
                    if (e[i]) m_idx = i;
                end
            end
        end
        m_prev = b;
    endtask

    task automatic step(input logic [3:0] b, input logic l);
        botones = b;
        listo   = l;
        @(posedge CLK);
        model_edge(b, l);
        #1;
        check("valido", 32'(comando_valido), 32'(m_pend));
        if (m_pend) begin
            check("comando", 32'(comando), 32'(m_idx));
            check("repeticion", 32'(repeticion), 32'(m_rep));
        end
    endtask

    initial begin
        int         ntrans;
        int         tcyc[$];
        logic [3:0] rb;

        // Reset with button 1 already held.
        RESET   = 1'b1;
        botones = 4'b0010;
        listo   = 1'b1;
        model_reset();
        n = 0;
        #2;
        check("rst_valido", 32'(comando_valido), 32'd0);
        check("rst_comando", 32'(comando), 32'd0);
        check("rst_repeticion", 32'(repeticion), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (3) step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b1);
        check("press_cmd", 32'(comando), 32'd1);
        step(4'b0010, 1'b1);
        check("one_cycle_valid", 32'(comando_valido), 32'd0);
        step(4'b0000, 1'b1);

        // Simultaneous edges: lowest index wins, the rest are discarded.
        step(4'b1010, 1'b1);
        check("prio_cmd", 32'(comando), 32'd1);
        repeat (4) step(4'b1000, 1'b1);
        check("discarded_edge", 32'(comando_valido), 32'd0);
        repeat (2) step(4'b0000, 1'b1);

        // Held button 2: transfers at t, t+R+1, t+R+P+2, t+R+2P+3.
        step(4'b0100, 1'b1);
        ntrans = 0;
        for (int i = 1; i <= 19; i++) begin
            if (comando_valido && listo) begin
                ntrans++;
                tcyc.push_back(i);
            end
            step(4'b0100, 1'b1);
        end
        check("repeat_count", 32'(ntrans), 32'd4);
        if (tcyc.size() == 4) begin
            check("repeat_first", 32'(tcyc[1] - tcyc[0]), 32'(R + 1));
            check("repeat_second", 32'(tcyc[2] - tcyc[1]), 32'(P + 1));
            check("repeat_third", 32'(tcyc[3] - tcyc[2]), 32'(P + 1));
        end
        repeat (2) step(4'b0000, 1'b1);

        // Consumer stall with release in the middle.
        step(4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step((i < 10) ? 4'b0001 : 4'b0000, 1'b0);
        end
        step(4'b0000, 1'b1);
        repeat (12) step(4'b0000, 1'b1);
        check("stall_no_repeat", 32'(comando_valido), 32'd0);

        // Release exactly at the counter-expiry edge.
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        repeat (R - 1) step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        check("expiry_release", 32'(comando_valido), 32'd0);
        repeat (10) step(4'b0000, 1'b1);

        // Asynchronous reset while a command is pending.
        step(4'b0100, 1'b0);
        check("pre_reset_valid", 32'(comando_valido), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_valido", 32'(comando_valido), 32'd0);
        check("async_comando", 32'(comando), 32'd0);
        check("async_repeticion", 32'(repeticion), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        repeat (5) step(4'b0100, 1'b1);
        check("post_reset_quiet", 32'(comando_valido), 32'd0);
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b1);
        check("post_reset_press", 32'(comando), 32'd2);
        step(4'b0000, 1'b1);

        // Randomized buttons and consumer readiness.
        rb = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rb = 4'($urandom_range(0, 15));
            step(rb, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
